fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Each requester presents a valid/ready/last burst interface.
- A grant is locked for one burst, ending on the last beat or after MAX_BURST beats, whichever comes first.
- The block sits directly in front of the FIFO and drives its write enable and write data from the granted requester.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DATA_WIDTH, 8: beat width; equals the FIFO width.
- MAX_BURST, 8: maximum beats per grant, for fairness; legal range 1..256.

Ports:
- arb_clk  in  1  clock.
- arb_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last-beat-of-burst flag.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accepted.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- arb_gnt  out  NUM_REQ  registered one-hot grant; all zeros when idle.
- arb_busy  out  1  high while a grant is held.

Behaviour:
- Clock and reset: one clock, arb_clk; reset arb_rst_n is asynchronous, active-low.
- Reset values: state IDLE, arb_gnt 0, arb_busy 0, rr_ptr 0, beat_cnt 0.
  - Combinational outputs therefore also reset: req_ready 0, fifo_wen 0, fifo_wdata 0.
- States: IDLE, BUSY.
- IDLE:
  - req_ready is all 0; fifo_wen is 0.
  - If any req_valid is high, select the first requester at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - Next cycle: arb_gnt = one-hot(sel), arb_busy = 1, state BUSY, beat_cnt = 0.
  - Latency from first valid to ready is 1 cycle.
- BUSY, with g = granted index:
  - req_ready[g] = !fifo_full; every other req_ready bit is 0.
  - fifo_wen = req_valid[g] & !fifo_full.
  - fifo_wdata = req_data[g], combinational mux. fifo_wdata is 0 in IDLE.
  - Beat accepted = fifo_wen. Each accepted beat increments beat_cnt.
  - Release condition: an accepted beat where req_last[g] = 1 or beat_cnt == MAX_BURST-1.
  - On release: state IDLE, arb_gnt 0, arb_busy 0, rr_ptr = (g+1) mod NUM_REQ.
  - One bubble cycle always separates consecutive grants.
- Stall cases:
  - fifo_full high: no beat accepted, beat_cnt holds, grant holds.
  - req_valid[g] low mid-burst: grant holds indefinitely; there is no timeout.
  - The arbiter never writes while fifo_full is high, even if the FIFO would accept a simultaneous read.
- Forced release: a burst truncated at MAX_BURST resumes as a new burst only after re-arbitration; req_last stays with the requester's data.
- Non-granted requesters: req_last and req_data are ignored.
- Rotation: rr_ptr advances only on release, never on IDLE cycles with no requests.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST) bits, minimum 1.
  - rr_ptr is $clog2(NUM_REQ) bits; it wraps explicitly when NUM_REQ is not a power of two.
- Reset mid-burst: immediate return to reset values. The partial burst is abandoned; the requester must restart it.
- Invariant: arb_gnt is zero or one-hot; a bench assertion checks this.

Decomposition:
- Package fifo_arb_pkg:
  - enum arb_state_t {ARB_IDLE, ARB_BUSY}.
  - Function onehot2idx.
- Sub-module fifo_rr_pick: combinational rotated-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: sel index, sel_valid.
- The top module holds the state register, counters and datapath mux.

Test Plan (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8):
1. Reset, then req_valid=0001 with a 3-beat burst 0x11,0x12,0x13 (last on 0x13) -> arb_gnt=0001 one cycle later; fifo_wen high for exactly 3 cycles with data 0x11,0x12,0x13; then arb_gnt=0; rr_ptr=1.
2. All four requesters valid with 1-beat bursts -> grant order 0,1,2,3,0 with one idle cycle between grants; each beat written once.
3. Requester 2 holds a 10-beat burst with no last before beat 10 -> grant released after 4 beats; requester 3 (valid) granted next; requester 2 regranted later and its remaining beats continue in order.
4. fifo_full asserted for 3 cycles in mid-burst -> req_ready=0 and fifo_wen=0 during those cycles; beat_cnt frozen; no data lost or duplicated after deassertion.
5. Granted requester drops valid for 5 cycles -> arb_gnt held; fifo_wen=0; other requesters remain at ready=0.
6. arb_rst_n pulsed low between clock edges mid-burst -> arb_gnt, arb_busy and req_ready go 0 immediately (asynchronously); after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    // Widest requester vector any instance may use.
    localparam int unsigned MAX_REQ = 16;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
    function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotated-priority picker: first requester at or after rr_ptr_i, wrapping.
module fifo_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    rr_ptr_i,
    output logic [IdxW-1:0]    sel_o,
    output logic               sel_valid_o
);

    // Walk the requesters starting from the pointer; keep the first hit.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        sel_o       = '0;
        sel_valid_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (!sel_valid_o && req_i[idx]) begin
                sel_o       = IdxW'(idx);
                sel_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters.
// A grant is held for one burst (last beat or MAX_BURST beats), then one idle
// cycle precedes the next arbitration.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          arb_clk,
    input  logic                          arb_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            arb_gnt,
    output logic                          arb_busy
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned BeatW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BURST - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BeatW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IdxW-1:0]    sel;
    logic               sel_valid;
    logic [IdxW-1:0]    g;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_pick (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .sel_o       (sel),
        .sel_valid_o (sel_valid)
    );

    // Granted index, recovered from the registered one-hot grant.
    assign g = IdxW'(onehot2idx(MAX_REQ'(gnt_q)));

    assign arb_gnt  = gnt_q;
    assign arb_busy = (state_q == ARB_BUSY);

    // State, grant, pointer and beat counter registers.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic plus the handshake and write-port datapath.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    state_d    = ARB_BUSY;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            ARB_BUSY: begin
                req_ready[g] = !fifo_full;
                fifo_wdata   = req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
                // Never write while full, even if a read would free a slot.
                if (req_valid[g] && !fifo_full) begin
                    fifo_wen   = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[g] || beat_cnt_q == LastBeat) begin
                        state_d    = ARB_IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (g == LastIdx) ? '0 : g + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_rr_arbiter;

    typedef struct {
        int unsigned idx;
        logic [7:0]  data;
    } wr_t;

    logic        arb_clk = 1'b0;
    logic        arb_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wen;
    logic [7:0]  fifo_wdata;
    logic        fifo_full;
    logic [3:0]  arb_gnt;
    logic        arb_busy;

    logic [8:0]  rq [4][$];   // per-requester beats {last, data}
    wr_t         exp_q [$];   // expected FIFO writes, in order
    logic [3:0]  tr_gnt [$];  // sampled grant trace
    logic        tr_wen [$];
    logic [3:0]  hold;
    logic [3:0]  s_gnt, s_ready;
    logic        s_wen, s_busy;
    int          tests = 0;
    int          fails = 0;

    fifo_rr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .arb_clk    (arb_clk),
        .arb_rst_n  (arb_rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .arb_gnt    (arb_gnt),
        .arb_busy   (arb_busy)
    );

    always #5 arb_clk = ~arb_clk;

    a_gnt_onehot: assert property (@(negedge arb_clk) disable iff (!arb_rst_n) $onehot0(arb_gnt));

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0 && !hold[i]) begin
                b = rq[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = b[8];
                req_data[i*8 +: 8] = b[7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d0, input int n);
        for (int k = 0; k < n; k++) rq[r].push_back({(k == n - 1), d0 + 8'(k)});
    endtask

    task automatic push_exp(input int unsigned r, input logic [7:0] d0, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = r;
            e.data = d0 + 8'(k);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample and score at negedge, advance requesters after posedge.
    task automatic step();
        logic [3:0] acc;
        wr_t        e;
        @(negedge arb_clk);
        s_gnt = arb_gnt; s_ready = req_ready; s_wen = fifo_wen; s_busy = arb_busy;
        tr_gnt.push_back(arb_gnt);
        tr_wen.push_back(fifo_wen);
        acc = req_valid & req_ready;
        tests++;
        if (!$onehot0(arb_gnt)) begin
            fails++; $display("FAIL gnt_onehot: arb_gnt=%b, required zero or one-hot", arb_gnt);
        end
        tests++;
        if (fifo_wen !== (|acc)) begin
            fails++; $display("FAIL wen_handshake: fifo_wen=%b, required %b", fifo_wen, |acc);
        end
        if (arb_gnt == 4'b0000) begin
            tests++;
            if (fifo_wdata !== 8'h00) begin
                fails++; $display("FAIL wdata_idle: fifo_wdata=%h, required 00", fifo_wdata);
            end
        end
        if (fifo_wen === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++; $display("FAIL unexpected_write: data=%h gnt=%b, required no write",
                                  fifo_wdata, arb_gnt);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wdata !== e.data || arb_gnt !== (4'b0001 << e.idx)) begin
                    fails++;
                    $display("FAIL write: data=%h gnt=%b, required data=%h gnt=%b",
                             fifo_wdata, arb_gnt, e.data, 4'b0001 << e.idx);
                end
            end
        end
        @(posedge arb_clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_q.delete();
        tr_gnt.delete();
        tr_wen.delete();
        hold = 4'b0000;
        fifo_full = 1'b0;
        drive();
    endtask

    task automatic reset_dut();
        arb_rst_n = 1'b0;
        clear_all();
        @(posedge arb_clk);
        #1;
        arb_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        arb_rst_n = 1'b0;
        clear_all();
        load(0, 8'hFF, 1);
        drive();
        @(posedge arb_clk);
        #1;
        tests += 5;
        if (arb_gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: %b, required 0000", arb_gnt); end
        if (arb_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: %b, required 0", arb_busy); end
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: %b, required 0000", req_ready); end
        if (fifo_wen !== 1'b0) begin fails++; $display("FAIL rst_wen: %b, required 0", fifo_wen); end
        if (fifo_wdata !== 8'h00) begin fails++; $display("FAIL rst_wdata: %h, required 00", fifo_wdata); end
        clear_all();
        arb_rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        logic [3:0] eg [5];
        eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        reset_dut();
        load(0, 8'h11, 3);
        push_exp(0, 8'h11, 3);
        drive();
        for (int k = 0; k < 5; k++) step();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (tr_gnt[k] !== eg[k] || tr_wen[k] !== (eg[k] != 4'b0000)) begin
                fails++;
                $display("FAIL t1_trace[%0d]: gnt=%b wen=%b, required gnt=%b wen=%b",
                         k, tr_gnt[k], tr_wen[k], eg[k], eg[k] != 4'b0000);
            end
        end
        // Pointer now at 1: requester 1 wins over requester 0.
        load(0, 8'h14, 1);
        load(1, 8'h15, 1);
        push_exp(1, 8'h15, 1);
        push_exp(0, 8'h14, 1);
        drive();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL t1_drain: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [11];
        eg = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        reset_dut();
        load(0, 8'hA0, 1); load(0, 8'hA1, 1);
        load(1, 8'hB0, 1); load(2, 8'hC0, 1); load(3, 8'hD0, 1);
        push_exp(0, 8'hA0, 1); push_exp(1, 8'hB0, 1); push_exp(2, 8'hC0, 1);
        push_exp(3, 8'hD0, 1); push_exp(0, 8'hA1, 1);
        drive();
        for (int k = 0; k < 11; k++) step();
        for (int k = 0; k < 11; k++) begin
            tests++;
            if (tr_gnt[k] !== eg[k]) begin
                fails++; $display("FAIL t2_gnt[%0d]: %b, required %b", k, tr_gnt[k], eg[k]);
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL t2_drain: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_max_burst();
        reset_dut();
        load(2, 8'h20, 10);
        load(3, 8'h30, 1);
        push_exp(2, 8'h20, 4);
        push_exp(3, 8'h30, 1);
        push_exp(2, 8'h24, 4);
        push_exp(2, 8'h28, 2);
        drive();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0 || rq[2].size() != 0) begin
            fails++; $display("FAIL t3_drain: %0d writes, %0d beats outstanding, required 0/0",
                              exp_q.size(), rq[2].size());
        end
    endtask

    task automatic test_fifo_full();
        reset_dut();
        load(1, 8'h40, 6);
        load(2, 8'h50, 1);
        push_exp(1, 8'h40, 4);
        push_exp(2, 8'h50, 1);
        push_exp(1, 8'h44, 2);
        drive();
        for (int k = 0; k < 3; k++) step();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (s_ready !== 4'b0000 || s_wen !== 1'b0 || s_gnt !== 4'b0010) begin
                fails++; $display("FAIL t4_full[%0d]: ready=%b wen=%b gnt=%b, required 0000/0/0010",
                                  k, s_ready, s_wen, s_gnt);
            end
        end
        fifo_full = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0 || rq[1].size() != 0) begin
            fails++; $display("FAIL t4_drain: %0d writes, %0d beats outstanding, required 0/0",
                              exp_q.size(), rq[1].size());
        end
    endtask

    task automatic test_valid_gap();
        reset_dut();
        load(2, 8'h60, 3);
        load(3, 8'h71, 1);
        push_exp(2, 8'h60, 3);
        push_exp(3, 8'h71, 1);
        drive();
        step();
        step();
        hold[2] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            tests++;
            if (s_gnt !== 4'b0100 || s_wen !== 1'b0 || s_ready !== 4'b0100 || s_busy !== 1'b1) begin
                fails++;
                $display("FAIL t5_gap[%0d]: gnt=%b wen=%b ready=%b busy=%b, required 0100/0/0100/1",
                         k, s_gnt, s_wen, s_ready, s_busy);
            end
        end
        hold[2] = 1'b0;
        drive();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL t5_drain: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        load(1, 8'h81, 1);
        load(2, 8'h90, 4);
        push_exp(1, 8'h81, 1);
        push_exp(2, 8'h90, 2);
        drive();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0 || s_gnt !== 4'b0100) begin
            fails++; $display("FAIL t6_pre: %0d outstanding gnt=%b, required 0 outstanding gnt=0100",
                              exp_q.size(), s_gnt);
        end
        #2;
        arb_rst_n = 1'b0;
        #1;
        tests += 3;
        if (arb_gnt !== 4'b0000) begin fails++; $display("FAIL t6_gnt: %b, required 0000", arb_gnt); end
        if (arb_busy !== 1'b0) begin fails++; $display("FAIL t6_busy: %b, required 0", arb_busy); end
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL t6_ready: %b, required 0000", req_ready); end
        clear_all();
        step();
        step();
        #2;
        arb_rst_n = 1'b1;
        load(0, 8'hA0, 1);
        load(3, 8'hB0, 1);
        push_exp(0, 8'hA0, 1);
        push_exp(3, 8'hB0, 1);
        drive();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL t6_drain: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hold      = 4'b0000;
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        arb_rst_n = 1'b1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_fifo_full();
        test_valid_gap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
